// File: rtl/instr_feeder.sv
// instr_feeder
//   Program-side source for the processor Din bus. A host loads a sequence of
//   8-bit words, each tagged with the 3-bit control-unit state in which the
//   processor consumes it. During playback the current word is presented on
//   din with zero latency. The pointer advances on the edge where proc_state
//   matches the tag of the current entry, which is the edge where the
//   processor latches din.
//
//   Optional build macro: FEEDER_LOOP_EN. When it is defined, playback wraps
//   to entry 0 after the last entry and stays in RUN until abort or clear.
//
// Ports
//   clk, rst              rising-edge clock; asynchronous active-high reset
//   wr_en/wr_data/wr_state  load one {state,data} entry at index count
//   start/abort/clear     single-cycle control pulses
//                         (priority clear > abort > start)
//   proc_state            processor control-unit state
//   din                   word for the processor (combinational from state/ptr)
//   running, done         registered FSM status
//   count                 number of loaded entries, saturates at DEPTH
//   wr_err                sticky error for dropped writes
module instr_feeder #(
    parameter int          DEPTH     = 16,
    parameter int          AW        = 4,
    parameter logic [7:0]  IDLE_WORD = 8'h00
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic [2:0]    wr_state,
    input  logic          start,
    input  logic          abort,
    input  logic          clear,
    input  logic [2:0]    proc_state,
    output logic [7:0]    din,
    output logic          running,
    output logic          done,
    output logic [AW:0]   count,
    output logic          wr_err
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [AW:0] ONE  = (AW+1)'(1);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    state_t       state;
    logic [AW:0]  ptr;          // one bit wider: parks at count (up to DEPTH) in DONE
    logic [10:0]  mem [DEPTH];  // {state[2:0], data[7:0]}

    logic         loading;
    logic         wr_ok;
    logic         wr_bad;
    logic [AW:0]  count_nx;
    logic [AW-1:0] ptr_idx;
    logic [10:0]  cur;
    logic         consume;
    logic         last;

    assign loading  = (state != S_RUN);
    // clear swallows a same-cycle write without flagging an error
    assign wr_ok    = wr_en && !clear && loading && (count != FULL);
    assign wr_bad   = wr_en && !clear && (!loading || (count == FULL));
    // a write landing together with start is counted by the playback decision
    assign count_nx = wr_ok ? count + ONE : count;

    assign ptr_idx  = ptr[AW-1:0];
    assign cur      = mem[ptr_idx];
    assign consume  = (state == S_RUN) && (proc_state == cur[10:8]);
    assign last     = (ptr == count - ONE);

    // Only the RUN state reads the buffer, and there ptr < count <= DEPTH.
    assign din = (state == S_RUN) ? cur[7:0] : IDLE_WORD;

    // Buffer storage has no reset; its contents are meaningless until loaded.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[count[AW-1:0]] <= {wr_state, wr_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            ptr     <= '0;
            count   <= '0;
            wr_err  <= 1'b0;
            running <= 1'b0;
            done    <= 1'b0;
        end else if (clear) begin
            state   <= S_IDLE;
            ptr     <= '0;
            count   <= '0;
            wr_err  <= 1'b0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            count <= count_nx;
            if (wr_bad)
                wr_err <= 1'b1;

            if (abort) begin
                state   <= S_IDLE;
                ptr     <= '0;
                running <= 1'b0;
                done    <= 1'b0;
            end else if (start && state != S_RUN) begin
                ptr <= '0;
                if (count_nx == '0) begin
                    state   <= S_DONE;
                    running <= 1'b0;
                    done    <= 1'b1;
                end else begin
                    state   <= S_RUN;
                    running <= 1'b1;
                    done    <= 1'b0;
                end
            end else if (consume) begin
                if (last) begin
`ifdef FEEDER_LOOP_EN
                    ptr <= '0;
`else
                    ptr     <= count;
                    state   <= S_DONE;
                    running <= 1'b0;
                    done    <= 1'b1;
`endif
                end else begin
                    ptr <= ptr + ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_feeder.sv
module tb_instr_feeder;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_en, start, abort, clear;
    logic [7:0]   wr_data;
    logic [2:0]   wr_state, proc_state;
    logic [7:0]   din;
    logic         running, done, wr_err;
    logic [AW:0]  count;

    int n_tests = 0;
    int n_fail  = 0;

    instr_feeder #(.DEPTH(DEPTH), .AW(AW), .IDLE_WORD(8'h00)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .wr_state(wr_state), .start(start), .abort(abort), .clear(clear),
        .proc_state(proc_state), .din(din), .running(running), .done(done),
        .count(count), .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 playing, 2 finished
    int        m_mode, m_ptr, m_cnt;
    bit        m_err;
    int        m_data [DEPTH];
    int        m_tag  [DEPTH];

    function automatic void model_reset();
        m_mode = 0; m_ptr = 0; m_cnt = 0; m_err = 0;
    endfunction

    function automatic int model_din();
        return (m_mode == 1) ? m_data[m_ptr] : 0;
    endfunction

    function automatic void model_step(input bit we, input int wd, input int ws,
                                       input bit st, input bit ab, input bit cl,
                                       input int ps);
        int new_cnt;
        if (cl) begin
            model_reset();
            return;
        end
        new_cnt = m_cnt;
        if (we) begin
            if (m_mode == 1 || m_cnt == DEPTH) m_err = 1;
            else begin
                m_data[m_cnt] = wd; m_tag[m_cnt] = ws; new_cnt = m_cnt + 1;
            end
        end
        if (ab) begin
            m_mode = 0; m_ptr = 0;
        end else if (st && m_mode != 1) begin
            m_ptr = 0;
            m_mode = (new_cnt == 0) ? 2 : 1;
        end else if (m_mode == 1 && ps == m_tag[m_ptr]) begin
            m_ptr++;
            if (m_ptr == m_cnt) begin
`ifdef FEEDER_LOOP_EN
                m_ptr = 0;
`else
                m_mode = 2;
`endif
            end
        end
        m_cnt = new_cnt;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_all();
        chk("din",     32'(din),     32'(model_din()));
        chk("running", 32'(running), 32'(m_mode == 1));
        chk("done",    32'(done),    32'(m_mode == 2));
        chk("count",   32'(count),   32'(m_cnt));
        chk("wr_err",  32'(wr_err),  32'(m_err));
    endtask

    // Drive one cycle of inputs (called at negedge), then check after the edge.
    task automatic step(input bit we, input int wd, input int ws, input bit st,
                        input bit ab, input bit cl, input int ps);
        wr_en = we; wr_data = 8'(wd); wr_state = 3'(ws);
        start = st; abort = ab; clear = cl; proc_state = 3'(ps);
        model_step(we, wd, ws, st, ab, cl, ps);
        @(posedge clk);
        @(negedge clk);
        wr_en = 0; start = 0; abort = 0; clear = 0;
        chk_all();
    endtask

    task automatic load(input int wd, input int ws);
        step(1, wd, ws, 0, 0, 0, 7);
    endtask

    task automatic do_clear();
        step(0, 0, 0, 0, 0, 1, 7);
    endtask

    task automatic do_start();
        step(0, 0, 0, 1, 0, 0, 7);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        int seq [5] = '{0, 1, 2, 3, 0};
        int exp_din [5] = '{8'h41, 8'h07, 8'h12, 8'h12, 8'h12};

        rst = 1; wr_en = 0; wr_data = 0; wr_state = 0;
        start = 0; abort = 0; clear = 0; proc_state = 7;
        model_reset();
        @(negedge clk);
        chk_all();
        chk("reset_din", 32'(din), 32'h00);
        rst = 0;
        @(negedge clk);
        chk_all();

        // basic playback with state matching
        load(8'h41, 0); load(8'h07, 1); load(8'h12, 0);
        do_start();
        for (int i = 0; i < 5; i++) begin
            chk("seq_din", 32'(din), 32'(exp_din[i]));
            step(0, 0, 0, 0, 0, 0, seq[i]);
        end
        chk("seq_done", 32'(done), 32'(1));
        chk("seq_din_idle", 32'(din), 32'h00);

        // replay same buffer, reset mid-run (asynchronous)
        do_start();
        step(0, 0, 0, 0, 0, 0, 0);
        #2 rst = 1;
        #1;
        model_reset();
        chk("arst_running", 32'(running), 0);
        chk("arst_done",    32'(done),    0);
        chk("arst_count",   32'(count),   0);
        chk("arst_din",     32'(din),     32'h00);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk_all();

        // stall
        load(8'hA5, 2);
        do_start();
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0, 0);
        chk("stall_din", 32'(din), 32'hA5);
        step(0, 0, 0, 0, 0, 0, 2);
        chk("stall_done", 32'(done), 1);

        // overflow
        do_clear();
        for (int i = 0; i < 17; i++) load(8'h80 + i, 0);
        chk("ovf_count", 32'(count), 16);
        chk("ovf_err", 32'(wr_err), 1);
        do_start();
        for (int i = 0; i < 15; i++) step(0, 0, 0, 0, 0, 0, 0);
        chk("ovf_last_entry", 32'(din), 32'h8F);
        do_clear();
        chk("clr_count", 32'(count), 0);
        chk("clr_err", 32'(wr_err), 0);

        // empty start, then write during run
        do_start();
        chk("empty_done", 32'(done), 1);
        chk("empty_running", 32'(running), 0);
        load(8'h33, 5);
        do_start();
        step(1, 8'h44, 1, 0, 0, 0, 0);
        chk("run_wr_err", 32'(wr_err), 1);
        chk("run_wr_count", 32'(count), 1);

        // write with start together lands first
        do_clear();
        step(1, 8'h5A, 3, 1, 0, 0, 7);
        chk("wr_start_din", 32'(din), 32'h5A);
        chk("wr_start_count", 32'(count), 1);

        // clear beats a same-cycle write without error
        step(1, 8'h11, 0, 0, 0, 1, 7);
        chk("clr_wr_count", 32'(count), 0);
        chk("clr_wr_err", 32'(wr_err), 0);

`ifdef FEEDER_LOOP_EN
        load(8'hE0, 0); load(8'hE1, 0);
        do_start();
        for (int i = 0; i < 6; i++) begin
            chk("loop_din", 32'(din), (i % 2 == 0) ? 32'hE0 : 32'hE1);
            step(0, 0, 0, 0, 0, 0, 0);
            chk("loop_done", 32'(done), 0);
        end
        step(0, 0, 0, 0, 1, 0, 0);
        chk("loop_abort_run", 32'(running), 0);
        chk("loop_abort_count", 32'(count), 2);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            bit we, st, ab, cl;
            int ps;
            we = ($urandom_range(0, 2) == 0);
            st = ($urandom_range(0, 9) == 0);
            ab = ($urandom_range(0, 39) == 0);
            cl = ($urandom_range(0, 79) == 0);
            if (m_mode == 1 && $urandom_range(0, 1) == 1) ps = m_tag[m_ptr];
            else ps = $urandom_range(0, 7);
            step(we, $urandom_range(0, 255), $urandom_range(0, 7), st, ab, cl, ps);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
